// File: rtl/isp_router_pkg.sv
// Shared constants and the stage-selection helper for the ISP stage router.
// The same helper picks both each stage's feed and the HDMI output source.
package isp_router_pkg;

  localparam int MAX_STAGES  = 16;
  localparam int BLANK_W     = 4;
  localparam int FRAME_CNT_W = 16;
  localparam int SEL_W       = 4;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } feed_sel_t;

  // Highest enabled stage strictly below index 'limit'; found=0 means the source.
  function automatic feed_sel_t highest_below(input logic [MAX_STAGES-1:0] mask,
                                              input int limit);
    feed_sel_t sel;
    sel = '0;
    for (int j = 0; j < MAX_STAGES; j++) begin
      if ((j < limit) && mask[j]) begin
        sel.found = 1'b1;
        sel.idx   = SEL_W'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/isp_frame_ctrl.sv
// Frame-boundary control: vsync edge detect, shadowed stage mask, blanking
// counter, source frame counter and the registered switch-pending flag.
module isp_frame_ctrl
  import isp_router_pkg::*;
#(
  parameter int                  N_STAGES     = 6,
  parameter int                  VS_POL       = 1,
  parameter int                  BLANK_FRAMES = 1,
  parameter logic [N_STAGES-1:0] RESET_MASK   = '0
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   src_vsync,
  input  logic [N_STAGES-1:0]    mask_req,
  output logic [N_STAGES-1:0]    active_mask,
  output logic                   switch_pending,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [BLANK_W-1:0]     blank_cnt
);

  localparam logic VS_ACT = (VS_POL != 0);

  logic                   vs_hist_q, vs_hist_d;
  logic                   primed_q, primed_d;
  logic [N_STAGES-1:0]    active_q, active_d;
  logic                   pending_q, pending_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [BLANK_W-1:0]     blank_q, blank_d;
  logic                   frame_start;

  always_comb begin
    vs_hist_d   = src_vsync;
    primed_d    = 1'b1;
    active_d    = active_q;
    blank_d     = blank_q;
    frame_cnt_d = frame_cnt_q;
    // The history is not trusted until it has sampled the line once after
    // reset, so releasing reset with vsync already active is not a frame start.
    frame_start = primed_q && (src_vsync == VS_ACT) && (vs_hist_q != VS_ACT);
    if (frame_start) begin
      active_d    = mask_req;
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      if (mask_req != active_q) begin
        blank_d = BLANK_W'(BLANK_FRAMES);
      end else if (blank_q != '0) begin
        blank_d = blank_q - BLANK_W'(1);
      end
    end
    pending_d = (mask_req != active_d);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_hist_q   <= ~VS_ACT;
      primed_q    <= 1'b0;
      active_q    <= RESET_MASK;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      blank_q     <= '0;
    end else begin
      vs_hist_q   <= vs_hist_d;
      primed_q    <= primed_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign active_mask    = active_q;
  assign switch_pending = pending_q;
  assign frame_cnt      = frame_cnt_q;
  assign blank_cnt      = blank_q;

endmodule

// File: rtl/isp_stage_router.sv
// Chains external ISP stages between the timing source and the HDMI encoder,
// with the enable mask applied only at frame starts so frames never tear.
module isp_stage_router
  import isp_router_pkg::*;
#(
  parameter int                  DW           = 24,
  parameter int                  N_STAGES     = 6,
  parameter int                  VS_POL       = 1,
  parameter int                  BLANK_FRAMES = 1,
  parameter logic [N_STAGES-1:0] RESET_MASK   = '0
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [DW-1:0]            src_data,
  input  logic                     src_de,
  input  logic                     src_href,
  input  logic                     src_vsync,
  input  logic [N_STAGES-1:0]      mask_req,
  output logic [N_STAGES*DW-1:0]   stg_in_data,
  output logic [N_STAGES-1:0]      stg_in_de,
  output logic [N_STAGES-1:0]      stg_in_href,
  output logic [N_STAGES-1:0]      stg_in_vsync,
  input  logic [N_STAGES*DW-1:0]   stg_out_data,
  input  logic [N_STAGES-1:0]      stg_out_de,
  input  logic [N_STAGES-1:0]      stg_out_href,
  input  logic [N_STAGES-1:0]      stg_out_vsync,
  output logic [DW-1:0]            out_data,
  output logic                     out_de,
  output logic                     out_href,
  output logic                     out_vsync,
  output logic [N_STAGES-1:0]      active_mask,
  output logic                     switch_pending,
  output logic [FRAME_CNT_W-1:0]   frame_cnt
);

  localparam logic VS_ACT = (VS_POL != 0);

  logic [N_STAGES-1:0]   active_w;
  logic [BLANK_W-1:0]    blank_cnt;
  logic [MAX_STAGES-1:0] mask_ext;
  // Entry N_STAGES selects the HDMI output source.
  feed_sel_t             feed_sel [N_STAGES+1];

  logic [DW-1:0] sel_data;
  logic          sel_de, sel_href, sel_vsync;

  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_de_q, out_de_d;
  logic          out_href_q, out_href_d;
  logic          out_vsync_q, out_vsync_d;

  isp_frame_ctrl #(
    .N_STAGES     (N_STAGES),
    .VS_POL       (VS_POL),
    .BLANK_FRAMES (BLANK_FRAMES),
    .RESET_MASK   (RESET_MASK)
  ) u_frame_ctrl (
    .pclk           (pclk),
    .rst            (rst),
    .src_vsync      (src_vsync),
    .mask_req       (mask_req),
    .active_mask    (active_w),
    .switch_pending (switch_pending),
    .frame_cnt      (frame_cnt),
    .blank_cnt      (blank_cnt)
  );

  assign mask_ext    = MAX_STAGES'(active_w);
  assign active_mask = active_w;

  always_comb begin
    for (int i = 0; i <= N_STAGES; i++) begin
      feed_sel[i] = highest_below(mask_ext, i);
    end
  end

  // Disabled stages are still fed so they keep seeing valid timing.
  always_comb begin
    stg_in_data  = '0;
    stg_in_de    = '0;
    stg_in_href  = '0;
    stg_in_vsync = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (feed_sel[i].found) begin
        stg_in_data[i*DW +: DW] = stg_out_data[int'(feed_sel[i].idx)*DW +: DW];
        stg_in_de[i]            = stg_out_de[int'(feed_sel[i].idx)];
        stg_in_href[i]          = stg_out_href[int'(feed_sel[i].idx)];
        stg_in_vsync[i]         = stg_out_vsync[int'(feed_sel[i].idx)];
      end else begin
        stg_in_data[i*DW +: DW] = src_data;
        stg_in_de[i]            = src_de;
        stg_in_href[i]          = src_href;
        stg_in_vsync[i]         = src_vsync;
      end
    end
  end

  always_comb begin
    sel_data  = src_data;
    sel_de    = src_de;
    sel_href  = src_href;
    sel_vsync = src_vsync;
    if (feed_sel[N_STAGES].found) begin
      sel_data  = stg_out_data[int'(feed_sel[N_STAGES].idx)*DW +: DW];
      sel_de    = stg_out_de[int'(feed_sel[N_STAGES].idx)];
      sel_href  = stg_out_href[int'(feed_sel[N_STAGES].idx)];
      sel_vsync = stg_out_vsync[int'(feed_sel[N_STAGES].idx)];
    end
  end

  // Blanking hides only pixel data; sync keeps flowing so the encoder stays locked.
  always_comb begin
    out_data_d  = (blank_cnt != '0) ? '0 : sel_data;
    out_de_d    = sel_de;
    out_href_d  = sel_href;
    out_vsync_d = sel_vsync;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_de_q    <= 1'b0;
      out_href_q  <= 1'b0;
      out_vsync_q <= ~VS_ACT;
    end else begin
      out_data_q  <= out_data_d;
      out_de_q    <= out_de_d;
      out_href_q  <= out_href_d;
      out_vsync_q <= out_vsync_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_de    = out_de_q;
  assign out_href  = out_href_q;
  assign out_vsync = out_vsync_q;

endmodule
